// File: rtl/store_pkg.sv
// Shared types and default parameters for the accumulator store path.
package store_pkg;

    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_AW    = 8;
    localparam int unsigned DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } store_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; a full push is refused even when a pop
// occurs in the same cycle.
module store_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; stale contents are never read while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/ac_store_unit.sv
// Buffers accumulator stores and drains them to data memory over a req/ack
// write handshake with a one-cycle request-low gap between writes.
module ac_store_unit
    import store_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [AW-1:0]           st_addr,
    input  logic [DW-1:0]           ac_data,
    input  logic                    flush,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic                    mem_ack,
    output logic [$clog2(DEPTH):0]  st_count,
    output logic                    st_idle
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

    logic [AW+DW-1:0] fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             can_issue;

    store_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (st_valid),
        .wr_data ({st_addr, ac_data}),
        .pop     (pop),
        .flush   (flush),
        .rd_data (fifo_rd_data),
        .count   (st_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A flush discards the head too, so nothing new issues in that cycle.
    assign can_issue = !fifo_empty && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (can_issue) state_d = ISSUE;
            ISSUE:   if (mem_ack)   state_d = GAP;
            GAP:     state_d = can_issue ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            IDLE, GAP: begin
                if (can_issue) begin
                    pop         = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = fifo_rd_data[AW+DW-1:DW];
                    mem_wdata_d = fifo_rd_data[DW-1:0];
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                end
            end
            default: mem_req_d = 1'b0;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign st_ready  = (st_count != CW'(DEPTH));
    assign st_idle   = (st_count == '0) && (state_q == IDLE);

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
